display_driver_row_scanner: RTL and testbench



---
 rtl/display_driver_row_scanner.sv | 165 ++++++++++++++++
 tb/tb_display_driver_row_scanner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_driver_row_scanner.sv
// rtl/display_driver_row_scanner.sv - HUB75 row/bit-plane scan sequencer; optional pause via DISPLAY_SCAN_PAUSE_EN
module display_driver_row_scanner #(
    parameter int bitwidth = 8,
    parameter int columns  = 32,
    parameter int rows     = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
`ifdef DISPLAY_SCAN_PAUSE_EN
    input  logic                                     enable,
`endif
    output logic                                     pulse_go,
    input  logic                                     pulse_complete,
    input  logic [$clog2(bitwidth)-1:0]              pulse_select,
    output logic [$clog2(rows)+$clog2(columns)-1:0]  fb_addr,
    input  logic [6*bitwidth-1:0]                    fb_data,
    output logic [5:0]                               panel_rgb,
    output logic                                     panel_clk,
    output logic                                     panel_lat,
    output logic                                     panel_oe,
    output logic [$clog2(rows)-1:0]                  panel_row
);

    localparam int SW = $clog2(bitwidth);
    localparam int CW = $clog2(columns);
    localparam int RW = $clog2(rows);

    typedef enum logic [2:0] {
        S_SHIFT_ADDR = 3'd0,
        S_SHIFT_DATA = 3'd1,
        S_SHIFT_CLK  = 3'd2,
        S_LATCH      = 3'd3,
        S_DISPLAY    = 3'd4,
        S_NEXT       = 3'd5
`ifdef DISPLAY_SCAN_PAUSE_EN
        , S_PAUSE    = 3'd6
`endif
    } state_t;

    state_t                state, state_d;
    logic [RW-1:0]         row, row_d;
    logic [CW-1:0]         col, col_d;
    logic [SW-1:0]         plane, plane_d;
    logic                  go_d, clk_d, lat_d, oe_d;
    logic [5:0]            rgb_d;
    logic [RW+CW-1:0]      fb_addr_d;
    logic [RW-1:0]         panel_row_d;

    logic [SW-1:0]         bit_idx;
    logic [bitwidth-1:0]   chan;
    logic [5:0]            sel_bits;

    // Pick the current bit plane from each of the six colour channels; select 0 is the MSB
    always_comb begin
        bit_idx  = SW'(bitwidth - 1) - pulse_select;
        chan     = '0;
        sel_bits = '0;
        for (int k = 0; k < 6; k++) begin
            chan        = fb_data[k*bitwidth +: bitwidth];
            sel_bits[k] = chan[bit_idx];
        end
    end

    // Next-state and next-output logic; panel stays blanked outside DISPLAY
    always_comb begin
        state_d     = state;
        row_d       = row;
        col_d       = col;
        plane_d     = plane;
        go_d        = 1'b0;
        clk_d       = 1'b0;
        lat_d       = 1'b0;
        oe_d        = 1'b1;
        rgb_d       = panel_rgb;
        fb_addr_d   = fb_addr;
        panel_row_d = panel_row;
        case (state)
            S_SHIFT_ADDR: begin
                fb_addr_d = {row, col};
                state_d   = S_SHIFT_DATA;
            end
            S_SHIFT_DATA: begin
                rgb_d   = sel_bits;
                state_d = S_SHIFT_CLK;
            end
            S_SHIFT_CLK: begin
                clk_d = 1'b1;
                if (col == CW'(columns - 1)) begin
                    col_d   = '0;
                    state_d = S_LATCH;
                end else begin
                    col_d   = col + 1'b1;
                    state_d = S_SHIFT_ADDR;
                end
            end
            S_LATCH: begin
                lat_d       = 1'b1;
                panel_row_d = row;
                state_d     = S_DISPLAY;
            end
            S_DISPLAY: begin
                // go drops on the same edge that sees complete, so the generator can clear it
                if (pulse_complete) begin
                    state_d = S_NEXT;
                end else begin
                    go_d = 1'b1;
                    oe_d = 1'b0;
                end
            end
            S_NEXT: begin
                if (plane == SW'(bitwidth - 1)) begin
                    plane_d = '0;
                    row_d   = row + 1'b1;
                end else begin
                    plane_d = plane + 1'b1;
                end
`ifdef DISPLAY_SCAN_PAUSE_EN
                state_d = enable ? S_SHIFT_ADDR : S_PAUSE;
`else
                state_d = S_SHIFT_ADDR;
`endif
            end
`ifdef DISPLAY_SCAN_PAUSE_EN
            S_PAUSE: begin
                if (enable) begin
                    state_d = S_SHIFT_ADDR;
                end
            end
`endif
            default: begin
                state_d = S_SHIFT_ADDR;
            end
        endcase
    end

    // State, counters and registered panel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SHIFT_ADDR;
            row       <= '0;
            col       <= '0;
            plane     <= '0;
            pulse_go  <= 1'b0;
            panel_clk <= 1'b0;
            panel_lat <= 1'b0;
            panel_oe  <= 1'b1;
            panel_rgb <= '0;
            fb_addr   <= '0;
            panel_row <= '0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            col       <= col_d;
            plane     <= plane_d;
            pulse_go  <= go_d;
            panel_clk <= clk_d;
            panel_lat <= lat_d;
            panel_oe  <= oe_d;
            panel_rgb <= rgb_d;
            fb_addr   <= fb_addr_d;
            panel_row <= panel_row_d;
        end
    end

endmodule

// File: tb/tb_display_driver_row_scanner.sv
// tb/tb_display_driver_row_scanner.sv - directed bench for the row scanner with a behavioural pulse generator
module tb_display_driver_row_scanner;

    localparam int BW   = 8;
    localparam int COLS = 4;
    localparam int ROWS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse_go;
    logic        pulse_complete;
    logic [2:0]  pulse_select;
    logic [2:0]  fb_addr;
    logic [47:0] fb_data;
    logic [5:0]  panel_rgb;
    logic        panel_clk;
    logic        panel_lat;
    logic        panel_oe;
    logic        panel_row;
`ifdef DISPLAY_SCAN_PAUSE_EN
    logic        enable = 1'b1;
`endif

    logic [47:0] fb_mem [8];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign fb_data = fb_mem[fb_addr];

    display_driver_row_scanner #(
        .bitwidth (BW),
        .columns  (COLS),
        .rows     (ROWS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef DISPLAY_SCAN_PAUSE_EN
        .enable         (enable),
`endif
        .pulse_go       (pulse_go),
        .pulse_complete (pulse_complete),
        .pulse_select   (pulse_select),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .panel_rgb      (panel_rgb),
        .panel_clk      (panel_clk),
        .panel_lat      (panel_lat),
        .panel_oe       (panel_oe),
        .panel_row      (panel_row)
    );

    // Pulse generator model: on-time 2^(BW-select)-1 counts, complete held until go drops
    logic       pg_busy;
    logic [8:0] pg_cnt;
    logic       pg_complete;
    logic [2:0] pg_select;
    logic [8:0] pg_target;

    assign pg_target      = 9'((1 << (BW - int'(pg_select))) - 1);
    assign pulse_complete = pg_complete;
    assign pulse_select   = pg_select;

    always @(posedge clk) begin
        if (rst) begin
            pg_busy     <= 1'b0;
            pg_cnt      <= '0;
            pg_complete <= 1'b0;
            pg_select   <= '0;
        end else if (pg_complete && !pulse_go) begin
            pg_complete <= 1'b0;
            pg_select   <= pg_select + 3'd1;
        end else if (pg_busy) begin
            if (pg_cnt == pg_target - 9'd1) begin
                pg_busy     <= 1'b0;
                pg_complete <= 1'b1;
            end else begin
                pg_cnt <= pg_cnt + 9'd1;
            end
        end else if (pulse_go && !pg_complete) begin
            pg_busy <= 1'b1;
            pg_cnt  <= '0;
        end
    end

    function automatic logic [5:0] exp_rgb(input int addr, input int p);
        logic [47:0] w;
        logic [5:0]  r;
        w = fb_mem[addr];
        for (int k = 0; k < 6; k++) r[k] = w[k*8 + 7 - p];
        return r;
    endfunction

    task automatic reset_dut;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if (pulse_go !== 1'b0)  begin fails++; $display("FAIL reset_go got %b want 0", pulse_go); end
        tests++; if (panel_oe !== 1'b1)  begin fails++; $display("FAIL reset_oe got %b want 1", panel_oe); end
        tests++; if (panel_lat !== 1'b0) begin fails++; $display("FAIL reset_lat got %b want 0", panel_lat); end
        tests++; if (panel_clk !== 1'b0) begin fails++; $display("FAIL reset_clk got %b want 0", panel_clk); end
        tests++; if (panel_rgb !== 6'h0) begin fails++; $display("FAIL reset_rgb got %h want 00", panel_rgb); end
        tests++; if (panel_row !== 1'b0) begin fails++; $display("FAIL reset_row got %b want 0", panel_row); end
        tests++; if (fb_addr !== 3'd0)   begin fails++; $display("FAIL reset_addr got %0d want 0", fb_addr); end
        rst = 1'b0;
    endtask

    task automatic test_shift_phase;
        int   rises;
        int   lat_cycle;
        logic prev;
        logic row_at;
        logic oe_at;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rises = 0; lat_cycle = -1; prev = 1'b0; row_at = 1'bx; oe_at = 1'bx;
        for (int i = 1; i <= 30 && lat_cycle < 0; i++) begin
            @(negedge clk);
            if (panel_clk && !prev) rises++;
            prev = panel_clk;
            if (panel_lat) begin lat_cycle = i; row_at = panel_row; oe_at = panel_oe; end
        end
        tests++; if (rises != 4)      begin fails++; $display("FAIL shift_clk_edges got %0d want 4", rises); end
        tests++; if (lat_cycle != 13) begin fails++; $display("FAIL first_lat_cycle got %0d want 13", lat_cycle); end
        tests++; if (row_at !== 1'b0) begin fails++; $display("FAIL first_lat_row got %b want 0", row_at); end
        tests++; if (oe_at !== 1'b1)  begin fails++; $display("FAIL first_lat_oe got %b want 1", oe_at); end
    endtask

    task automatic test_rgb_data;
        int   p;
        int   c;
        logic prev;
        logic [5:0] e;
        reset_dut();
        p = 0; c = 0; prev = 1'b0;
        for (int i = 0; i < 2000 && p < 8; i++) begin
            @(negedge clk);
            if (panel_clk && !prev) begin
                e = exp_rgb(c, p);
                tests++;
                if (panel_rgb !== e) begin
                    fails++;
                    $display("FAIL rgb_plane%0d_col%0d got %h want %h", p, c, panel_rgb, e);
                end
                c++;
            end
            prev = panel_clk;
            if (panel_lat) begin
                tests++;
                if (c != 4) begin fails++; $display("FAIL rgb_cols_plane%0d got %0d want 4", p, c); end
                c = 0;
                p++;
            end
        end
        tests++; if (p != 8) begin fails++; $display("FAIL rgb_planes_seen got %0d want 8", p); end
    endtask

    task automatic test_display_timing;
        int   runs;
        int   low;
        logic prev_oe;
        int   want;
        reset_dut();
        runs = 0; low = 0; prev_oe = 1'b1;
        for (int i = 0; i < 2000 && runs < 8; i++) begin
            @(negedge clk);
            if (panel_lat) begin
                tests++;
                if (panel_oe !== 1'b1) begin fails++; $display("FAIL lat_while_lit got oe=%b want 1", panel_oe); end
            end
            if (!panel_oe) low++;
            if (panel_oe && !prev_oe) begin
                want = (1 << (BW - runs)) + 1;
                tests++;
                if (low != want) begin fails++; $display("FAIL oe_low_plane%0d got %0d want %0d", runs, low, want); end
                runs++;
                low = 0;
            end
            prev_oe = panel_oe;
        end
        tests++; if (runs != 8) begin fails++; $display("FAIL display_runs got %0d want 8", runs); end
    endtask

    task automatic test_row_sequence;
        int   n;
        int   changes;
        logic prev_row;
        logic want;
        reset_dut();
        n = 0; changes = 0; prev_row = 1'b0;
        for (int i = 0; i < 3000 && n < 17; i++) begin
            @(negedge clk);
            if (panel_row !== prev_row) begin
                changes++;
                tests++;
                if (panel_lat !== 1'b1) begin fails++; $display("FAIL row_change_outside_lat got lat=%b want 1", panel_lat); end
            end
            prev_row = panel_row;
            if (panel_lat) begin
                want = 1'((n / 8) % 2);
                tests++;
                if (panel_row !== want) begin fails++; $display("FAIL row_at_lat%0d got %b want %b", n, panel_row, want); end
                n++;
            end
        end
        tests++; if (n != 17)      begin fails++; $display("FAIL row_lats_seen got %0d want 17", n); end
        tests++; if (changes != 2) begin fails++; $display("FAIL row_changes got %0d want 2", changes); end
    endtask

    task automatic test_reset_mid_display;
        int   waited;
        int   low;
        int   rises;
        logic prev;
        logic [5:0] first_rgb;
        reset_dut();
        waited = 0;
        while (panel_oe !== 1'b0 && waited < 200) begin @(negedge clk); waited++; end
        tests++; if (panel_oe !== 1'b0) begin fails++; $display("FAIL mid_reset_reach_display got oe=%b want 0", panel_oe); end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (panel_oe !== 1'b1) begin fails++; $display("FAIL mid_reset_oe got %b want 1", panel_oe); end
        tests++; if (pulse_go !== 1'b0) begin fails++; $display("FAIL mid_reset_go got %b want 0", pulse_go); end
        rst = 1'b0;
        rises = 0; prev = 1'b0; first_rgb = 6'h3f; waited = 0;
        while (panel_lat !== 1'b1 && waited < 100) begin
            @(negedge clk); waited++;
            if (panel_clk && !prev) begin
                if (rises == 0) first_rgb = panel_rgb;
                rises++;
            end
            prev = panel_clk;
        end
        tests++; if (first_rgb !== 6'h01) begin fails++; $display("FAIL mid_reset_col0_rgb got %h want 01", first_rgb); end
        tests++; if (panel_row !== 1'b0)  begin fails++; $display("FAIL mid_reset_row got %b want 0", panel_row); end
        waited = 0;
        while (panel_oe !== 1'b0 && waited < 20) begin @(negedge clk); waited++; end
        low = 0;
        while (panel_oe === 1'b0 && low < 400) begin @(negedge clk); low++; end
        tests++; if (low != 257) begin fails++; $display("FAIL mid_reset_oe_low got %0d want 257", low); end
    endtask

`ifdef DISPLAY_SCAN_PAUSE_EN
    task automatic test_pause;
        int waited;
        int low;
        int activity;
        reset_dut();
        waited = 0;
        while (panel_oe !== 1'b0 && waited < 200) begin @(negedge clk); waited++; end
        enable = 1'b0;
        low = 0;
        while (panel_oe === 1'b0 && low < 400) begin @(negedge clk); low++; end
        tests++; if (low != 257) begin fails++; $display("FAIL pause_plane_finish got %0d want 257", low); end
        activity = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (panel_clk !== 1'b0 || panel_oe !== 1'b1 || pulse_go !== 1'b0) activity++;
        end
        tests++; if (activity != 0) begin fails++; $display("FAIL pause_idle got %0d active cycles want 0", activity); end
        enable = 1'b1;
        waited = 0;
        while (panel_oe !== 1'b0 && waited < 100) begin @(negedge clk); waited++; end
        low = 0;
        while (panel_oe === 1'b0 && low < 400) begin @(negedge clk); low++; end
        tests++; if (low != 129) begin fails++; $display("FAIL pause_resume_plane1 got %0d want 129", low); end
    endtask
`endif

    initial begin
        for (int a = 0; a < 8; a++) begin
            for (int k = 0; k < 6; k++) fb_mem[a][k*8 +: 8] = 8'(8'h5A * (a + 1) + 8'h33 * k);
        end
        fb_mem[0] = 48'h0000_0000_0080;

        test_reset();
        test_shift_phase();
        test_rgb_data();
        test_display_timing();
        test_row_sequence();
        test_reset_mid_display();
`ifdef DISPLAY_SCAN_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
